// File: rtl/seg7_scan_ctrl_if.sv
// Load handshake bundle for seg7_scan_ctrl.
//   load_valid  producer offers a new display value
//   load_value  four BCD nibbles, [15:12] = leftmost digit 3, [3:0] = digit 0
//   load_lz     leading-zero blanking request travelling with load_value
//   load_ready  consumer's pending buffer is empty, so an offer is accepted
interface seg7_scan_ctrl_if;
    logic        load_valid;
    logic [15:0] load_value;
    logic        load_lz;
    logic        load_ready;

    modport master (
        output load_valid,
        output load_value,
        output load_lz,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_value,
        input  load_lz,
        output load_ready
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 4-digit 7-segment scan controller.
// Each digit slot is BLANK_CYC cycles of all-anodes-off dead time followed by
// ON_CYC cycles with that digit's anode driven low. New values are double
// buffered (pending -> active) and swapped only at frame end.
// Ports:
//   clk         system clock, rising edge
//   reset_n     synchronous active-low reset
//   enable      scan enable; low blanks the display and parks the scan at digit 0
//   bus         load handshake (slave side)
//   bcd         nibble for the external BCD-to-7-segment decoder (4'hA = dash)
//   anode       active-low digit enables, bit n = digit n
//   frame_done  one-cycle pulse in the last ON cycle of digit 3
module seg7_scan_ctrl #(
    parameter int unsigned ON_CYC    = 100000,
    parameter int unsigned BLANK_CYC = 1000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    seg7_scan_ctrl_if.slave         bus,
    output logic [3:0]              bcd,
    output logic [3:0]              anode,
    output logic                    frame_done
);

    localparam int unsigned MaxCyc = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
    localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

    localparam logic [CntW-1:0] OnLast    = CntW'(ON_CYC - 1);
    localparam logic [CntW-1:0] OnPenult  = CntW'(ON_CYC - 2);
    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYC - 1);
    localparam logic            OnSingle  = (ON_CYC == 1);

    typedef enum logic {StBlank, StOn} state_t;

    state_t          state;
    logic [1:0]      dsel;
    logic [CntW-1:0] cnt;

    logic [15:0]     act_value;
    logic            act_lz;
    logic [15:0]     pend_value;
    logic            pend_lz;
    logic            pend_full;

    logic            xfer;
    logic            accept;
    logic [15:0]     act_value_nxt;
    logic [1:0]      dsel_inc;
    logic [3:0]      lz_blank;

    // Nibble for a digit, with out-of-range codes folded onto the dash code.
    function automatic logic [3:0] nib_code(input logic [15:0] v, input logic [1:0] sel);
        logic [3:0] n;
        n = v[{sel, 2'b00} +: 4];
        return (n > 4'd9) ? 4'hA : n;
    endfunction

    assign bus.load_ready = ~pend_full;
    assign accept         = bus.load_valid & ~pend_full;
    // frame_done is high exactly in the last ON cycle of digit 3, so it doubles
    // as the swap strobe: the whole next frame sees one consistent value.
    assign xfer           = frame_done & pend_full;
    assign act_value_nxt  = xfer ? pend_value : act_value;
    assign dsel_inc       = dsel + 2'd1;

    // A digit is blanked only if it and every digit to its left are zero.
    assign lz_blank[3] = act_lz & (act_value[15:12] == 4'h0);
    assign lz_blank[2] = lz_blank[3] & (act_value[11:8] == 4'h0);
    assign lz_blank[1] = lz_blank[2] & (act_value[7:4] == 4'h0);
    assign lz_blank[0] = 1'b0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= StBlank;
            dsel       <= 2'd0;
            cnt        <= '0;
            anode      <= 4'hF;
            bcd        <= 4'h0;
            frame_done <= 1'b0;
            act_value  <= 16'h0000;
            act_lz     <= 1'b0;
            pend_value <= 16'h0000;
            pend_lz    <= 1'b0;
            pend_full  <= 1'b0;
        end else begin
            // Handshake runs regardless of enable.
            if (xfer) begin
                act_value <= pend_value;
                act_lz    <= pend_lz;
                pend_full <= 1'b0;
            end else if (accept) begin
                pend_value <= bus.load_value;
                pend_lz    <= bus.load_lz;
                pend_full  <= 1'b1;
            end

            if (!enable) begin
                state      <= StBlank;
                dsel       <= 2'd0;
                cnt        <= '0;
                anode      <= 4'hF;
                frame_done <= 1'b0;
                bcd        <= nib_code(act_value_nxt, 2'd0);
            end else begin
                unique case (state)
                    StBlank: begin
                        if (cnt == BlankLast) begin
                            state      <= StOn;
                            cnt        <= '0;
                            anode      <= lz_blank[dsel] ? 4'hF : ~(4'b0001 << dsel);
                            frame_done <= OnSingle & (dsel == 2'd3);
                        end else begin
                            cnt        <= cnt + 1'b1;
                            frame_done <= 1'b0;
                        end
                    end
                    StOn: begin
                        if (cnt == OnLast) begin
                            state      <= StBlank;
                            cnt        <= '0;
                            dsel       <= dsel_inc;
                            anode      <= 4'hF;
                            frame_done <= 1'b0;
                            // Present next digit's code for the full dead time.
                            bcd        <= nib_code(act_value_nxt, dsel_inc);
                        end else begin
                            cnt        <= cnt + 1'b1;
                            frame_done <= ~OnSingle & (cnt == OnPenult) & (dsel == 2'd3);
                        end
                    end
                    default: begin
                        state <= StBlank;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

    localparam int unsigned OnCyc    = 4;
    localparam int unsigned BlankCyc = 2;
    localparam int          Slot     = 6;
    localparam int          Frame    = 24;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] bcd;
    logic [3:0] anode;
    logic       frame_done;

    seg7_scan_ctrl_if bus();

    seg7_scan_ctrl #(
        .ON_CYC    (OnCyc),
        .BLANK_CYC (BlankCyc)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .bus        (bus),
        .bcd        (bcd),
        .anode      (anode),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Reference model: t counts cycles since the scan last (re)started at
    // digit 0's dead time; everything visible is a function of t and the
    // value shown in the current frame.
    int          t = 0;
    logic [15:0] m_act = 16'h0;
    logic        m_lz = 1'b0;
    logic [15:0] m_pend = 16'h0;
    logic        m_pend_lz = 1'b0;
    logic        m_pf = 1'b0;

    int n_checks = 0;
    int n_pass = 0;

    // Expected {anode, bcd, frame_done, load_ready} for the current cycle.
    function automatic logic [9:0] model_out();
        int p;
        int slot;
        logic lit;
        logic blank;
        logic [15:0] upper;
        logic [3:0] nib;
        logic [3:0] an;
        p     = t % Frame;
        slot  = p / Slot;
        lit   = (p % Slot) >= BlankCyc;
        upper = m_act >> (4 * slot);
        nib   = upper[3:0];
        blank = m_lz && (slot > 0) && (upper == 16'h0);
        an    = (lit && !blank) ? ~(4'b0001 << slot) : 4'hF;
        return {an, (nib > 4'd9) ? 4'hA : nib, p == Frame - 1, !m_pf};
    endfunction

    // One clock: model follows the inputs sampled at the edge; returns at negedge.
    task automatic tick();
        logic fd;
        @(posedge clk);
        if (!reset_n) begin
            t = 0; m_act = 16'h0; m_lz = 1'b0; m_pf = 1'b0;
        end else begin
            fd = (t % Frame) == Frame - 1;
            if (fd && m_pf) begin
                m_act = m_pend; m_lz = m_pend_lz; m_pf = 1'b0;
            end else if (bus.load_valid && !m_pf) begin
                m_pend = bus.load_value; m_pend_lz = bus.load_lz; m_pf = 1'b1;
            end
            t = enable ? t + 1 : 0;
        end
        @(negedge clk);
    endtask

    task automatic align(input int pos);
        for (int i = 0; i < 2 * Frame && (t % Frame) != pos; i++) tick();
    endtask

    task automatic offer_once(input logic [15:0] v, input logic lz);
        bus.load_valid = 1'b1; bus.load_value = v; bus.load_lz = lz;
        tick();
        bus.load_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0;
        bus.load_valid = 1'b1; bus.load_value = 16'h1234; bus.load_lz = 1'b1;
        repeat (3) tick();
        n_checks++; if (anode !== 4'hF) $display("FAIL reset_anode: got %h want f", anode); else n_pass++;
        n_checks++; if (bcd !== 4'h0) $display("FAIL reset_bcd: got %h want 0", bcd); else n_pass++;
        n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_fd: got %b want 0", frame_done); else n_pass++;
        n_checks++; if (bus.load_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.load_ready); else n_pass++;
        bus.load_valid = 1'b0; bus.load_lz = 1'b0;
        reset_n = 1'b1; enable = 1'b1;
    endtask

    task automatic test_idle_scan();
        int fd_cnt = 0;
        logic [9:0] e;
        repeat (2 * Frame) begin
            tick();
            e = model_out();
            n_checks++;
            if ({anode, bcd, frame_done, bus.load_ready} !== e)
                $display("FAIL idle_scan t=%0d: got %b want %b", t, {anode, bcd, frame_done, bus.load_ready}, e);
            else n_pass++;
            if (frame_done === 1'b1) fd_cnt++;
        end
        n_checks++; if (fd_cnt != 2) $display("FAIL idle_fd_count: got %0d want 2", fd_cnt); else n_pass++;
    endtask

    task automatic test_load();
        logic [3:0] seen [4];
        logic [3:0] want [4];
        logic prev_fd = 1'b0;
        logic [9:0] e;
        want[0] = 4'h4; want[1] = 4'h3; want[2] = 4'h2; want[3] = 4'h1;
        for (int s = 0; s < 4; s++) seen[s] = 4'hx;
        align(10);
        offer_once(16'h1234, 1'b0);
        n_checks++; if (bus.load_ready !== 1'b0) $display("FAIL load_ready_low: got %b want 0", bus.load_ready); else n_pass++;
        repeat (40) begin
            tick();
            e = model_out();
            n_checks++;
            if ({anode, bcd, frame_done, bus.load_ready} !== e)
                $display("FAIL load_scan t=%0d: got %b want %b", t, {anode, bcd, frame_done, bus.load_ready}, e);
            else n_pass++;
            if (prev_fd) begin
                n_checks++; if (bus.load_ready !== 1'b1) $display("FAIL load_ready_back: got %b want 1", bus.load_ready); else n_pass++;
            end
            if (m_act == 16'h1234 && (t % Slot) == BlankCyc) seen[(t % Frame) / Slot] = bcd;
            prev_fd = frame_done;
        end
        for (int s = 0; s < 4; s++) begin
            n_checks++;
            if (seen[s] !== want[s]) $display("FAIL load_digit%0d: got %h want %h", s, seen[s], want[s]);
            else n_pass++;
        end
    endtask

    task automatic test_lz();
        int lit;
        int lit_hi;
        logic [9:0] e;
        align(0);
        offer_once(16'h0050, 1'b1);
        lit = 0; lit_hi = 0;
        repeat (2 * Frame) begin
            tick();
            e = model_out();
            n_checks++;
            if ({anode, bcd, frame_done, bus.load_ready} !== e)
                $display("FAIL lz_scan t=%0d: got %b want %b", t, {anode, bcd, frame_done, bus.load_ready}, e);
            else n_pass++;
            if (m_act == 16'h0050 && m_lz) begin
                if (anode != 4'hF) lit++;
                if (anode[3:2] != 2'b11) lit_hi++;
            end
        end
        n_checks++; if (lit != 8) $display("FAIL lz_0050_lit: got %0d want 8", lit); else n_pass++;
        n_checks++; if (lit_hi != 0) $display("FAIL lz_0050_hi: got %0d want 0", lit_hi); else n_pass++;

        align(0);
        offer_once(16'h0000, 1'b1);
        lit = 0; lit_hi = 0;
        repeat (2 * Frame) begin
            tick();
            e = model_out();
            n_checks++;
            if ({anode, bcd, frame_done, bus.load_ready} !== e)
                $display("FAIL lz0_scan t=%0d: got %b want %b", t, {anode, bcd, frame_done, bus.load_ready}, e);
            else n_pass++;
            if (m_act == 16'h0000 && m_lz) begin
                if (anode != 4'hF) lit++;
                if (anode[3:1] != 3'b111) lit_hi++;
            end
        end
        n_checks++; if (lit != 4) $display("FAIL lz_0000_lit: got %0d want 4", lit); else n_pass++;
        n_checks++; if (lit_hi != 0) $display("FAIL lz_0000_hi: got %0d want 0", lit_hi); else n_pass++;
    endtask

    task automatic test_err_digits();
        logic [3:0] seen [4];
        logic [3:0] want [4];
        logic [9:0] e;
        want[0] = 4'h0; want[1] = 4'hA; want[2] = 4'h9; want[3] = 4'hA;
        for (int s = 0; s < 4; s++) seen[s] = 4'hx;
        align(0);
        offer_once(16'hF9C0, 1'b0);
        repeat (2 * Frame) begin
            tick();
            e = model_out();
            n_checks++;
            if ({anode, bcd, frame_done, bus.load_ready} !== e)
                $display("FAIL err_scan t=%0d: got %b want %b", t, {anode, bcd, frame_done, bus.load_ready}, e);
            else n_pass++;
            if (m_act == 16'hF9C0 && (t % Slot) == BlankCyc) seen[(t % Frame) / Slot] = bcd;
        end
        for (int s = 0; s < 4; s++) begin
            n_checks++;
            if (seen[s] !== want[s]) $display("FAIL err_digit%0d: got %h want %h", s, seen[s], want[s]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int cyc = 0;
        int t1 = -1;
        int t2 = -1;
        logic acc;
        logic [9:0] e;
        align(0);
        bus.load_valid = 1'b1; bus.load_value = 16'h1111; bus.load_lz = 1'b0;
        repeat (3 * Frame) begin
            acc = bus.load_valid && bus.load_ready;
            tick();
            cyc++;
            e = model_out();
            n_checks++;
            if ({anode, bcd, frame_done, bus.load_ready} !== e)
                $display("FAIL b2b_scan t=%0d: got %b want %b", t, {anode, bcd, frame_done, bus.load_ready}, e);
            else n_pass++;
            if (acc) begin
                if (bus.load_value == 16'h1111) bus.load_value = 16'h2222;
                else bus.load_valid = 1'b0;
            end
            if (anode == 4'b1110 && bcd == 4'h1 && t1 < 0) t1 = cyc;
            if (anode == 4'b1110 && bcd == 4'h2 && t2 < 0) t2 = cyc;
        end
        bus.load_valid = 1'b0;
        n_checks++;
        if (t1 < 0 || t2 < 0 || t2 - t1 != Frame)
            $display("FAIL b2b_spacing: got first=%0d second=%0d want spacing %0d", t1, t2, Frame);
        else n_pass++;
    endtask

    task automatic test_enable();
        int blanks;
        logic [9:0] e;
        align(14);
        tick();
        enable = 1'b0;
        tick();
        n_checks++; if (anode !== 4'hF) $display("FAIL en_off_anode: got %h want f", anode); else n_pass++;
        n_checks++; if (frame_done !== 1'b0) $display("FAIL en_off_fd: got %b want 0", frame_done); else n_pass++;
        repeat (4) begin
            tick();
            e = model_out();
            n_checks++;
            if ({anode, bcd, frame_done, bus.load_ready} !== e)
                $display("FAIL en_off_scan t=%0d: got %b want %b", t, {anode, bcd, frame_done, bus.load_ready}, e);
            else n_pass++;
        end
        enable = 1'b1;
        blanks = (anode == 4'hF) ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            e = model_out();
            n_checks++;
            if ({anode, bcd, frame_done, bus.load_ready} !== e)
                $display("FAIL en_on_scan t=%0d: got %b want %b", t, {anode, bcd, frame_done, bus.load_ready}, e);
            else n_pass++;
            if (anode != 4'hF) break;
            blanks++;
        end
        n_checks++; if (blanks != 2) $display("FAIL en_restart_blank: got %0d want 2", blanks); else n_pass++;
        n_checks++; if (anode !== 4'b1110) $display("FAIL en_restart_digit: got %b want 1110", anode); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        logic [9:0] e;
        align(2);
        bus.load_valid = 1'b1; bus.load_value = 16'h5678; bus.load_lz = 1'b0;
        tick();
        bus.load_value = 16'h9999;
        repeat (10) tick();
        reset_n = 1'b0;
        tick();
        n_checks++; if (bus.load_ready !== 1'b1) $display("FAIL rst_mid_ready: got %b want 1", bus.load_ready); else n_pass++;
        n_checks++; if (anode !== 4'hF) $display("FAIL rst_mid_anode: got %h want f", anode); else n_pass++;
        n_checks++; if (bcd !== 4'h0) $display("FAIL rst_mid_bcd: got %h want 0", bcd); else n_pass++;
        reset_n = 1'b1; bus.load_valid = 1'b0;
        repeat (30) begin
            tick();
            e = model_out();
            n_checks++;
            if ({anode, bcd, frame_done, bus.load_ready} !== e)
                $display("FAIL rst_mid_scan t=%0d: got %b want %b", t, {anode, bcd, frame_done, bus.load_ready}, e);
            else n_pass++;
            if (anode != 4'hF && bcd != 4'h0) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL rst_mid_active_zero: got %0d nonzero digits want 0", bad); else n_pass++;
    endtask

    task automatic test_random();
        logic [9:0] e;
        repeat (600) begin
            bus.load_valid = ($urandom_range(0, 3) == 0);
            bus.load_value = 16'($urandom) >> (4 * $urandom_range(0, 4));
            bus.load_lz    = 1'($urandom_range(0, 1));
            if (!enable) enable = ($urandom_range(0, 3) == 0);
            else         enable = ($urandom_range(0, 63) != 0);
            tick();
            e = model_out();
            n_checks++;
            if ({anode, bcd, frame_done, bus.load_ready} !== e)
                $display("FAIL random_scan t=%0d: got %b want %b", t, {anode, bcd, frame_done, bus.load_ready}, e);
            else n_pass++;
        end
        bus.load_valid = 1'b0;
        enable = 1'b1;
    endtask

    initial begin
        bus.load_valid = 1'b0;
        bus.load_value = 16'h0;
        bus.load_lz    = 1'b0;
        test_reset();
        test_idle_scan();
        test_load();
        test_lz();
        test_err_digits();
        test_back_to_back();
        test_enable();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not end, checks so far %0d", n_checks);
        $fatal(1);
    end

endmodule
